mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - data-memory load/store unit
// Stalls the pipeline across a request/response handshake and aligns/extends load and store lanes.
module mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MEM_M,
   input  logic [31:0] MEM_ALU_out,
   input  logic [31:0] MEM_WriteDatain,
   input  logic [31:0] MEM_instruction,
   output logic        dm_req,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t      r_state;
   state_t      w_next;
   logic        r_dm_req;
   logic [31:0] r_dm_addr;
   logic [3:0]  r_dm_we;
   logic [31:0] r_dm_wdata;
   logic        r_is_write;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [31:0] r_load_data;
   logic        r_load_valid;

   logic [2:0]  w_f3;
   logic [1:0]  w_off;
   logic        w_access;
   logic        w_is_write;
   logic [1:0]  w_size;
   logic        w_misaligned;
   logic        w_start;
   logic [3:0]  w_we;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic        w_unused;

   assign w_f3       = MEM_instruction[14:12];
   assign w_off      = MEM_ALU_out[1:0];
   assign w_access   = MEM_M[1] | MEM_M[0];
   // MemWrite wins when both control bits are set
   assign w_is_write = MEM_M[0];
   assign w_unused   = &{1'b0, MEM_instruction[31:15], MEM_instruction[11:0]};

   // Unknown funct3 encodings fall back to word size for both directions
   always_comb begin
      w_size = SZ_WORD;
      if (w_is_write) begin
         case (w_f3)
            3'b000:  w_size = SZ_BYTE;
            3'b001:  w_size = SZ_HALF;
            default: w_size = SZ_WORD;
         endcase
      end else begin
         case (w_f3)
            3'b000, 3'b100: w_size = SZ_BYTE;
            3'b001, 3'b101: w_size = SZ_HALF;
            default:        w_size = SZ_WORD;
         endcase
      end
   end

   assign w_misaligned = ((w_size == SZ_HALF) && w_off[0]) ||
                         ((w_size == SZ_WORD) && (w_off != 2'b00));
   assign w_start      = (r_state == IDLE) && w_access && !w_misaligned;

   always_comb begin
      w_we    = 4'b1111;
      w_wdata = MEM_WriteDatain;
      case (w_size)
         SZ_BYTE: begin
            w_we    = 4'b0001 << w_off;
            w_wdata = {4{MEM_WriteDatain[7:0]}};
         end
         SZ_HALF: begin
            w_we    = 4'b0011 << w_off;
            w_wdata = {2{MEM_WriteDatain[15:0]}};
         end
         default: begin
            w_we    = 4'b1111;
            w_wdata = MEM_WriteDatain;
         end
      endcase
   end

   assign w_byte = dm_rdata[{r_off, 3'b000} +: 8];
   assign w_half = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

   always_comb begin
      w_load_ext = dm_rdata;
      case (r_f3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_ext = {24'h0, w_byte};
         3'b101:  w_load_ext = {16'h0, w_half};
         default: w_load_ext = dm_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = REQ;
         REQ:     if (dm_ready) w_next = r_is_write ? DONE : WAIT_R;
         WAIT_R:  if (dm_rvalid) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // DONE drops the stall so the pipeline advances on that edge
   always_comb begin
      mem_stall = 1'b0;
      misalign  = 1'b0;
      case (r_state)
         IDLE: begin
            mem_stall = w_access && !w_misaligned;
            misalign  = rst && w_access && w_misaligned;
         end
         REQ:     mem_stall = 1'b1;
         WAIT_R:  mem_stall = 1'b1;
         default: mem_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dm_req     <= 1'b0;
         r_dm_addr    <= 32'h0;
         r_dm_we      <= 4'h0;
         r_dm_wdata   <= 32'h0;
         r_is_write   <= 1'b0;
         r_f3         <= 3'b000;
         r_off        <= 2'b00;
         r_load_data  <= 32'h0;
         r_load_valid <= 1'b0;
      end else begin
         r_load_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_dm_req   <= 1'b1;
                  r_dm_addr  <= {MEM_ALU_out[31:2], 2'b00};
                  r_dm_we    <= w_is_write ? w_we : 4'h0;
                  r_dm_wdata <= w_is_write ? w_wdata : 32'h0;
                  r_is_write <= w_is_write;
                  r_f3       <= w_f3;
                  r_off      <= w_off;
               end
            end
            REQ: begin
               if (dm_ready) begin
                  r_dm_req <= 1'b0;
                  r_dm_we  <= 4'h0;
               end
            end
            WAIT_R: begin
               if (dm_rvalid) begin
                  r_load_data  <= w_load_ext;
                  r_load_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dm_req     = r_dm_req;
   assign dm_addr    = r_dm_addr;
   assign dm_we      = r_dm_we;
   assign dm_wdata   = r_dm_wdata;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic [1:0]  MEM_M;
   logic [31:0] MEM_ALU_out;
   logic [31:0] MEM_WriteDatain;
   logic [31:0] MEM_instruction;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [3:0]  dm_we;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misalign;

   int n_checks = 0;
   int n_fail   = 0;

   mem_lsu dut (
      .clk             (clk),
      .rst             (rst),
      .MEM_M           (MEM_M),
      .MEM_ALU_out     (MEM_ALU_out),
      .MEM_WriteDatain (MEM_WriteDatain),
      .MEM_instruction (MEM_instruction),
      .dm_req          (dm_req),
      .dm_addr         (dm_addr),
      .dm_we           (dm_we),
      .dm_wdata        (dm_wdata),
      .dm_ready        (dm_ready),
      .dm_rvalid       (dm_rvalid),
      .dm_rdata        (dm_rdata),
      .mem_stall       (mem_stall),
      .load_data       (load_data),
      .load_valid      (load_valid),
      .misalign        (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Runs one access with an always-ready memory and reports what was observed
   task automatic do_access(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [31:0] rd,
                            output int n_req, output int n_stall, output int n_lv, output int c_done,
                            output logic [3:0] q_we, output logic [31:0] q_wdata,
                            output logic [31:0] q_addr, output logic [31:0] ld);
      n_req = 0; n_stall = 0; n_lv = 0; c_done = -1;
      q_we = 4'hx; q_wdata = 32'hx; q_addr = 32'hx;
      @(negedge clk);
      MEM_M = m; MEM_ALU_out = a; MEM_WriteDatain = wd;
      MEM_instruction = {17'h0, f3, 12'h0};
      dm_ready = 1'b1; dm_rvalid = 1'b1; dm_rdata = rd;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (dm_req === 1'b1) begin
            n_req++; q_we = dm_we; q_wdata = dm_wdata; q_addr = dm_addr;
         end
         if (mem_stall === 1'b1) n_stall++;
         if (load_valid === 1'b1) n_lv++;
         if (c > 0 && mem_stall === 1'b0 && c_done < 0) begin
            c_done = c;
            MEM_M = 2'b00;
         end
         @(negedge clk);
      end
      MEM_M = 2'b00;
      ld = load_data;
   endtask

   task automatic test_reset();
      rst = 1'b0; MEM_M = 2'b00; MEM_ALU_out = 32'h0; MEM_WriteDatain = 32'h0;
      MEM_instruction = 32'h0; dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
      @(negedge clk); #1;
      n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req: got %0h want 0", dm_req); end
      n_checks++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dm_addr: got %0h want 0", dm_addr); end
      n_checks++; if (dm_we !== 4'h0) begin n_fail++; $display("FAIL reset_dm_we: got %0h want 0", dm_we); end
      n_checks++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_wdata: got %0h want 0", dm_wdata); end
      n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_load_data: got %0h want 0", load_data); end
      n_checks++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL reset_load_valid: got %0h want 0", load_valid); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_mem_stall: got %0h want 0", mem_stall); end
      MEM_M = 2'b10; MEM_ALU_out = 32'h101; MEM_instruction = {17'h0, 3'b010, 12'h0};
      #1;
      n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %0h want 0", misalign); end
      MEM_ALU_out = 32'h100;
      @(negedge clk); #1;
      n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_req: got %0h want 0", dm_req); end
      MEM_M = 2'b00;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lw_basic();
      int nr, ns, nl, cd; logic [3:0] we; logic [31:0] wd, ad, ld;
      do_access(2'b10, 32'h100, 32'h0, 3'b010, 32'hDEADBEEF, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (nr !== 1) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 1", nr); end
      n_checks++; if (ns !== 3) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 3", ns); end
      n_checks++; if (nl !== 1) begin n_fail++; $display("FAIL lw_load_valid_cycles: got %0d want 1", nl); end
      n_checks++; if (cd !== 3) begin n_fail++; $display("FAIL lw_done_cycle: got %0d want 3", cd); end
      n_checks++; if (ad !== 32'h100 || we !== 4'h0) begin n_fail++; $display("FAIL lw_req_fields: addr %0h we %0h want 100 0", ad, we); end
      n_checks++; if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %0h want deadbeef", ld); end
   endtask

   task automatic test_load_ext();
      int nr, ns, nl, cd; logic [3:0] we; logic [31:0] wd, ad, ld;
      do_access(2'b10, 32'h103, 32'h0, 3'b000, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %0h want ffffff80", ld); end
      n_checks++; if (ad !== 32'h100) begin n_fail++; $display("FAIL lb_word_addr: got %0h want 100", ad); end
      do_access(2'b10, 32'h103, 32'h0, 3'b100, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %0h want 80", ld); end
      do_access(2'b10, 32'h102, 32'h0, 3'b101, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'h00008011) begin n_fail++; $display("FAIL lhu_data: got %0h want 8011", ld); end
      do_access(2'b10, 32'h102, 32'h0, 3'b001, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'hFFFF8011) begin n_fail++; $display("FAIL lh_data: got %0h want ffff8011", ld); end
      do_access(2'b10, 32'h100, 32'h0, 3'b000, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'h00000033) begin n_fail++; $display("FAIL lb_lane0_data: got %0h want 33", ld); end
      do_access(2'b10, 32'h100, 32'h0, 3'b011, 32'h80112233, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (ld !== 32'h80112233) begin n_fail++; $display("FAIL load_other_f3: got %0h want 80112233", ld); end
   endtask

   task automatic test_store_strobes();
      int nr, ns, nl, cd; logic [3:0] we; logic [31:0] wd, ad, ld, ld0;
      ld0 = load_data;
      do_access(2'b01, 32'h11, 32'h12345678, 3'b000, 32'h0, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (we !== 4'b0010 || wd !== 32'h78787878 || ad !== 32'h10) begin n_fail++; $display("FAIL sb_lane1: we %0h data %0h addr %0h want 2 78787878 10", we, wd, ad); end
      n_checks++; if (cd !== 2 || ns !== 2) begin n_fail++; $display("FAIL store_latency: done %0d stall %0d want 2 2", cd, ns); end
      do_access(2'b01, 32'h10, 32'h12345678, 3'b001, 32'h0, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (we !== 4'b0011 || wd !== 32'h56785678) begin n_fail++; $display("FAIL sh_lane0: we %0h data %0h want 3 56785678", we, wd); end
      do_access(2'b01, 32'h24, 32'h12345678, 3'b111, 32'h0, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (we !== 4'b1111 || wd !== 32'h12345678) begin n_fail++; $display("FAIL store_other_f3: we %0h data %0h want f 12345678", we, wd); end
      do_access(2'b11, 32'h30, 32'h0BADF00D, 3'b010, 32'h55555555, nr, ns, nl, cd, we, wd, ad, ld);
      n_checks++; if (we !== 4'b1111 || wd !== 32'h0BADF00D || nl !== 0 || cd !== 2) begin n_fail++; $display("FAIL m11_is_write: we %0h data %0h lv %0d done %0d want f badf00d 0 2", we, wd, nl, cd); end
      n_checks++; if (ld !== ld0) begin n_fail++; $display("FAIL store_keeps_load_data: got %0h want %0h", ld, ld0); end
   endtask

   task automatic test_store_stall();
      int bad; logic [31:0] ld0;
      ld0 = load_data;
      @(negedge clk);
      MEM_M = 2'b01; MEM_ALU_out = 32'h202; MEM_WriteDatain = 32'h0000ABCD;
      MEM_instruction = {17'h0, 3'b001, 12'h0};
      dm_ready = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h99999999;
      #1;
      n_checks++; if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL sh_idle: stall %0h req %0h want 1 0", mem_stall, dm_req); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         if (dm_req !== 1'b1 || dm_we !== 4'b1100 || dm_wdata !== 32'hABCDABCD ||
             dm_addr !== 32'h200 || mem_stall !== 1'b1) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sh_hold_stable: got %0d bad cycles want 0 (we %0h data %0h)", bad, dm_we, dm_wdata); end
      @(negedge clk);
      dm_ready = 1'b1; #1;
      n_checks++; if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL sh_req_at_ready: req %0h stall %0h want 1 1", dm_req, mem_stall); end
      @(negedge clk); #1;
      n_checks++; if (mem_stall !== 1'b0 || dm_req !== 1'b0 || load_valid !== 1'b0) begin n_fail++; $display("FAIL sh_done: stall %0h req %0h lv %0h want 0 0 0", mem_stall, dm_req, load_valid); end
      MEM_M = 2'b00;
      @(negedge clk); #1;
      n_checks++; if (dm_req !== 1'b0 || load_data !== ld0) begin n_fail++; $display("FAIL sh_after: req %0h load_data %0h want 0 %0h", dm_req, load_data, ld0); end
   endtask

   task automatic test_misalign();
      int nreq, nlv, nmis, nst; logic [31:0] ld0;
      ld0 = load_data;
      @(negedge clk);
      MEM_M = 2'b10; MEM_ALU_out = 32'h101; MEM_instruction = {17'h0, 3'b010, 12'h0};
      dm_ready = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h12121212;
      nreq = 0; nlv = 0; nmis = 0; nst = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (dm_req === 1'b1) nreq++;
         if (load_valid === 1'b1) nlv++;
         if (misalign === 1'b1) nmis++;
         if (mem_stall === 1'b1) nst++;
         @(negedge clk);
      end
      n_checks++; if (nmis !== 4 || nst !== 0) begin n_fail++; $display("FAIL lw_mis_flags: misalign %0d stall %0d want 4 0", nmis, nst); end
      n_checks++; if (nreq !== 0 || nlv !== 0 || load_data !== ld0) begin n_fail++; $display("FAIL lw_mis_effects: req %0d lv %0d data %0h want 0 0 %0h", nreq, nlv, load_data, ld0); end
      MEM_M = 2'b01; MEM_ALU_out = 32'h203; MEM_instruction = {17'h0, 3'b001, 12'h0}; #1;
      n_checks++; if (misalign !== 1'b1 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL sh_mis: misalign %0h stall %0h want 1 0", misalign, mem_stall); end
      MEM_M = 2'b10; MEM_ALU_out = 32'h102; #1;
      n_checks++; if (misalign !== 1'b0 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL lh_aligned: misalign %0h stall %0h want 0 1", misalign, mem_stall); end
      MEM_M = 2'b00;
      @(negedge clk); #1;
      n_checks++; if (dm_req !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL mis_idle_after: req %0h misalign %0h want 0 0", dm_req, misalign); end
   endtask

   task automatic test_back_to_back();
      int phase, nreq, c_sd, c_lv, c_r1, c_r2;
      logic [3:0] we1, we2; logic [31:0] ad2, ld;
      phase = 0; nreq = 0; c_sd = -1; c_lv = -1; c_r1 = -1; c_r2 = -1;
      we1 = 4'hx; we2 = 4'hx; ad2 = 32'hx; ld = 32'hx;
      @(negedge clk);
      MEM_M = 2'b01; MEM_ALU_out = 32'h10; MEM_WriteDatain = 32'hCAFEF00D;
      MEM_instruction = {17'h0, 3'b010, 12'h0};
      dm_ready = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h13579BDF;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (dm_req === 1'b1) begin
            nreq++;
            if (nreq == 1) begin we1 = dm_we; c_r1 = c; end
            else if (nreq == 2) begin we2 = dm_we; ad2 = dm_addr; c_r2 = c; end
         end
         if (phase == 0 && c > 0 && mem_stall === 1'b0) begin
            c_sd = c; phase = 1; MEM_M = 2'b10;
         end else if (phase == 1 && load_valid === 1'b1) begin
            c_lv = c; ld = load_data; phase = 2; MEM_M = 2'b00;
         end
         @(negedge clk);
      end
      MEM_M = 2'b00;
      n_checks++; if (nreq !== 2) begin n_fail++; $display("FAIL b2b_req_count: got %0d want 2", nreq); end
      n_checks++; if (we1 !== 4'b1111 || we2 !== 4'b0000 || ad2 !== 32'h10) begin n_fail++; $display("FAIL b2b_order: we1 %0h we2 %0h addr2 %0h want f 0 10", we1, we2, ad2); end
      n_checks++; if (c_r1 !== 1 || c_sd !== 2 || c_r2 !== 4 || c_lv !== 6) begin n_fail++; $display("FAIL b2b_timing: r1 %0d sdone %0d r2 %0d lv %0d want 1 2 4 6", c_r1, c_sd, c_r2, c_lv); end
      n_checks++; if (ld !== 32'h13579BDF) begin n_fail++; $display("FAIL b2b_load_data: got %0h want 13579bdf", ld); end
   endtask

   task automatic test_reset_mid();
      int nlv, nreq, nst;
      @(negedge clk);
      MEM_M = 2'b10; MEM_ALU_out = 32'h40; MEM_instruction = {17'h0, 3'b010, 12'h0};
      dm_ready = 1'b1; dm_rvalid = 1'b0; dm_rdata = 32'h77777777;
      @(negedge clk);
      @(negedge clk); #1;
      n_checks++; if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin n_fail++; $display("FAIL wait_r_state: stall %0h req %0h want 1 0", mem_stall, dm_req); end
      rst = 1'b0; MEM_M = 2'b00; #1;
      n_checks++; if (dm_req !== 1'b0 || dm_we !== 4'h0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_dm_outputs: req %0h we %0h addr %0h data %0h want 0 0 0 0", dm_req, dm_we, dm_addr, dm_wdata); end
      n_checks++; if (load_data !== 32'h0 || load_valid !== 1'b0 || misalign !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_lsu_outputs: data %0h lv %0h mis %0h stall %0h want 0 0 0 0", load_data, load_valid, misalign, mem_stall); end
      @(negedge clk);
      rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hFFFFFFFF;
      nlv = 0; nreq = 0; nst = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (load_valid === 1'b1) nlv++;
         if (dm_req === 1'b1) nreq++;
         if (mem_stall === 1'b1) nst++;
         @(negedge clk);
      end
      dm_rvalid = 1'b0;
      n_checks++; if (nlv !== 0 || nreq !== 0 || nst !== 0) begin n_fail++; $display("FAIL midrst_abandon: lv %0d req %0d stall %0d want 0 0 0", nlv, nreq, nst); end
      n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL midrst_load_data: got %0h want 0", load_data); end
   endtask

   initial begin
      test_reset();
      test_lw_basic();
      test_load_ext();
      test_store_strobes();
      test_store_stall();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
